// File: rtl/matrix_stream_chunker.sv
// Row-stream to COMPUTE_DIM1 x COMPUTE_DIM0 chunk reshaper; MATRIX_STREAM_CHUNKER_DOUBLE_BUF_EN selects ping-pong banks.
// First chunk of a strip is valid 1 cycle after its last row; in_ready drops while the write bank is full.
module matrix_stream_chunker #(
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data [TOTAL_DIM0],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [COMPUTE_DIM0*COMPUTE_DIM1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    localparam int DEPTH0 = TOTAL_DIM0 / COMPUTE_DIM0;
    localparam int DEPTH1 = TOTAL_DIM1 / COMPUTE_DIM1;
    localparam int ROW_W  = (COMPUTE_DIM1 > 1) ? $clog2(COMPUTE_DIM1) : 1;
    localparam int K_W    = (DEPTH0 > 1) ? $clog2(DEPTH0) : 1;
    localparam int S_W    = (DEPTH1 > 1) ? $clog2(DEPTH1) : 1;
    localparam int COL_W  = (TOTAL_DIM0 > 1) ? $clog2(TOTAL_DIM0) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(COMPUTE_DIM1 - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(DEPTH0 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(DEPTH1 - 1);

    if ((TOTAL_DIM0 % COMPUTE_DIM0 != 0) || (TOTAL_DIM1 % COMPUTE_DIM1 != 0)) begin : g_bad_dims
        $fatal(1, "matrix_stream_chunker: TOTAL_DIM must be a multiple of COMPUTE_DIM");
    end

`ifdef MATRIX_STREAM_CHUNKER_DOUBLE_BUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    logic [DATA_WIDTH-1:0] mem [NBANK][COMPUTE_DIM1][TOTAL_DIM0];
    logic [ROW_W-1:0] in_row;
    logic [K_W-1:0]   k;
    logic [S_W-1:0]   s;
    logic             wr_bank;
    logic             rd_bank;
    logic             in_fire;
    logic             out_fire;
    logic             fill_done;
    logic             drain_done;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign fill_done  = in_fire && (in_row == ROW_LAST);
    assign drain_done = out_fire && (k == K_LAST);
    assign out_last   = out_valid && (k == K_LAST) && (s == S_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_row <= '0;
            k      <= '0;
            s      <= '0;
        end else begin
            if (in_fire)
                in_row <= fill_done ? '0 : in_row + 1'b1;
            if (out_fire)
                k <= drain_done ? '0 : k + 1'b1;
            if (drain_done)
                s <= (s == S_LAST) ? '0 : s + 1'b1;
        end
    end

    // Data storage has no reset: bank flags alone decide what is ever presented.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < TOTAL_DIM0; c++)
                mem[wr_bank][in_row][c] <= in_data[c];
        end
    end

    for (genvar r = 0; r < COMPUTE_DIM1; r++) begin : g_chunk_row
        for (genvar c = 0; c < COMPUTE_DIM0; c++) begin : g_chunk_col
            assign out_data[r*COMPUTE_DIM0 + c] =
                mem[rd_bank][r][COL_W'(int'(k) * COMPUTE_DIM0 + c)];
        end
    end

`ifdef MATRIX_STREAM_CHUNKER_DOUBLE_BUF_EN
    logic [1:0] full;
    logic       wr_ptr;
    logic       rd_ptr;

    // A fill and a drain can only coincide on different banks, so both updates apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (fill_done) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (drain_done) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

    assign in_ready  = !full[wr_ptr];
    assign out_valid = full[rd_ptr];
    assign wr_bank   = wr_ptr;
    assign rd_bank   = rd_ptr;
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state;
    state_t state_nx;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
        case (state)
            FILL:    if (in_valid && (in_row == ROW_LAST)) state_nx = DRAIN;
            DRAIN:   if (out_ready && (k == K_LAST))       state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_chunker.sv
// Directed bench: default 4x4/2x2 instance plus a DEPTH0 = 1 instance (2-column matrix).
module tb_matrix_stream_chunker;
    logic       clk;
    logic       rst;
    logic [7:0] in_data  [4];
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data [4];
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] in_data2  [2];
    logic       in_valid2;
    logic       in_ready2;
    logic [7:0] out_data2 [4];
    logic       out_valid2;
    logic       out_ready2;
    logic       out_last2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] rows[$];
    logic [31:0] chunks[$];
    logic        lasts[$];
    int          acc_t[$];
    int          out_t[$];
    logic [15:0] rows2[$];
    logic [31:0] chunks2[$];
    logic        lasts2[$];

    logic [31:0] exp_m0   [4] = '{32'h00010405, 32'h02030607, 32'h080c090d & 32'h0, 32'h0};
    logic [31:0] exp_m100 [4] = '{32'h64656869, 32'h66676a6b, 32'h6c6d7071, 32'h6e6f7273};
    logic [31:0] exp_d2   [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};

    matrix_stream_chunker dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    matrix_stream_chunker #(
        .TOTAL_DIM0(2), .TOTAL_DIM1(4), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .DATA_WIDTH(8)
    ) dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chunk_at(input int i);
        return (i < chunks.size()) ? chunks[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] chunk2_at(input int i);
        return (i < chunks2.size()) ? chunks2[i] : 32'hxxxxxxxx;
    endfunction
    function automatic logic last_at(input int i);
        return (i < lasts.size()) ? lasts[i] : 1'bx;
    endfunction
    function automatic logic last2_at(input int i);
        return (i < lasts2.size()) ? lasts2[i] : 1'bx;
    endfunction
    function automatic int acc_at(input int i);
        return (i < acc_t.size()) ? acc_t[i] : -1000;
    endfunction
    function automatic int out_at(input int i);
        return (i < out_t.size()) ? out_t[i] : -2000;
    endfunction

    task automatic push_matrix(input int base, input int nrows);
        logic [31:0] w;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 4; c++) w[8*c +: 8] = 8'(base + r*4 + c);
            rows.push_back(w);
        end
    endtask

    task automatic push_matrix2(input int base);
        logic [15:0] w;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) w[8*c +: 8] = 8'(base + r*2 + c);
            rows2.push_back(w);
        end
    endtask

    task automatic clear();
        rows.delete(); chunks.delete(); lasts.delete(); acc_t.delete(); out_t.delete();
    endtask

    // Called at a falling edge: drive inputs, log handshakes that the next rising edge completes.
    task automatic tick();
        in_valid = (rows.size() > 0);
        for (int c = 0; c < 4; c++) in_data[c] = in_valid ? rows[0][8*c +: 8] : 8'h00;
        in_valid2 = (rows2.size() > 0);
        for (int c = 0; c < 2; c++) in_data2[c] = in_valid2 ? rows2[0][8*c +: 8] : 8'h00;
        if (in_valid && in_ready) begin
            acc_t.push_back(cyc);
            void'(rows.pop_front());
        end
        if (out_valid && out_ready) begin
            chunks.push_back({out_data[0], out_data[1], out_data[2], out_data[3]});
            lasts.push_back(out_last);
            out_t.push_back(cyc);
        end
        if (in_valid2 && in_ready2) void'(rows2.pop_front());
        if (out_valid2 && out_ready2) begin
            chunks2.push_back({out_data2[0], out_data2[1], out_data2[2], out_data2[3]});
            lasts2.push_back(out_last2);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        exp_m0[2] = 32'h080c090d & 32'h0 | 32'h08090c0d;
        exp_m0[3] = 32'h0a0b0e0f;
        rst = 1'b1; out_ready = 1'b0; out_ready2 = 1'b0;
        in_valid = 1'b0; in_valid2 = 1'b0;
        for (int c = 0; c < 4; c++) in_data[c] = 8'h00;
        for (int c = 0; c < 2; c++) in_data2[c] = 8'h00;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready2", in_ready2, 1);
        chk("rst_out_valid2", out_valid2, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_last", out_last, 0);

        // Full matrix with the sink always ready.
        clear();
        push_matrix(0, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && chunks.size() < 4; i++) tick();
        chk("m0_count", chunks.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m0_chunk%0d", i), chunk_at(i), exp_m0[i]);
            chk($sformatf("m0_last%0d", i), last_at(i), (i == 3));
        end
        chk("lat_strip0", out_at(0), acc_at(1) + 1);
        chk("lat_strip1", out_at(2), acc_at(3) + 1);
`ifdef MATRIX_STREAM_CHUNKER_DOUBLE_BUF_EN
        chk("rows_back_to_back", acc_at(3), acc_at(0) + 3);
        chk("chunks_back_to_back", out_at(3), out_at(0) + 3);
`else
        chk("row2_after_drain", acc_at(2), out_at(1) + 1);
        chk("in_ready_low_span", acc_at(2) - acc_at(1), 3);
`endif

        // Sink stalls on the first chunk for 5 cycles.
        clear();
        push_matrix(0, 4);
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid%0d", i), out_valid, 1);
            chk($sformatf("stall_data%0d", i), {out_data[0], out_data[1], out_data[2], out_data[3]},
                exp_m0[0]);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && chunks.size() < 4; i++) tick();
        chk("stall_count", chunks.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_chunk%0d", i), chunk_at(i), exp_m0[i]);
            chk($sformatf("stall_last%0d", i), last_at(i), (i == 3));
        end

        // Reset after a complete first strip, before any chunk leaves.
        clear();
        push_matrix(0, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && acc_t.size() < 2; i++) tick();
        chk("pre_rst_rows", acc_t.size(), 2);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        push_matrix(100, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && chunks.size() < 4; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        chk("m100_count", chunks.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("m100_chunk%0d", i), chunk_at(i), exp_m100[i]);

        // Single-chunk strips, two matrices back to back.
        push_matrix2(0);
        push_matrix2(8);
        out_ready2 = 1'b1;
        for (int i = 0; i < 60 && chunks2.size() < 4; i++) tick();
        chk("d2_count", chunks2.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d2_chunk%0d", i), chunk2_at(i), exp_d2[i]);
            chk($sformatf("d2_last%0d", i), last2_at(i), (i == 1 || i == 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule
